// File: rtl/operand_stage_pkg.sv
// Shared definitions for the operand-fetch stage. The ALU and the controller FSM use them too:
// the datapath geometry and the shifter operation codes.
package operand_stage_pkg;

  localparam int W    = 16;
  localparam int NREG = 8;
  localparam int AW   = 3;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_e;

endpackage

// File: rtl/operand_stage_if.sv
// Control and data bundle between the controller/writeback side and the operand stage.
// The master drives the register-file and operand controls. The slave returns the ALU operands.
interface operand_stage_if #(
  parameter int W  = operand_stage_pkg::W,
  parameter int AW = operand_stage_pkg::AW
);

  logic          write;
  logic [AW-1:0] writenum;
  logic [W-1:0]  data_in;
  logic [AW-1:0] readnum;
  logic          loada;
  logic          loadb;
  logic [1:0]    shift;
  logic          asel;
  logic          bsel;
  logic [W-1:0]  sximm5;
  logic [W-1:0]  Ain;
  logic [W-1:0]  Bin;
  logic [W-1:0]  data_out;

  modport master (
    output write, writenum, data_in, readnum, loada, loadb,
    output shift, asel, bsel, sximm5,
    input  Ain, Bin, data_out
  );

  modport slave (
    input  write, writenum, data_in, readnum, loada, loadb,
    input  shift, asel, bsel, sximm5,
    output Ain, Bin, data_out
  );

endinterface

// File: rtl/operand_regfile.sv
// General register file: NREG x W storage, one write port and one combinational read port.
// Defining OPERAND_BYPASS_EN makes the read port write-through when writenum == readnum.
module operand_regfile #(
  parameter int W    = 16,
  parameter int NREG = 8,
  parameter int AW   = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          write,
  input  logic [AW-1:0] writenum,
  input  logic [W-1:0]  data_in,
  input  logic [AW-1:0] readnum,
  output logic [W-1:0]  data_out
);

  logic [W-1:0] regs [NREG];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (write) begin
      regs[writenum] <= data_in;
    end
  end

`ifdef OPERAND_BYPASS_EN
  // Gate the bypass with reset so the read port reads zero for the whole reset period.
  always_comb begin
    data_out = regs[readnum];
    if (write && !reset && (writenum == readnum)) data_out = data_in;
  end
`else
  assign data_out = regs[readnum];
`endif

endmodule

// File: rtl/operand_stage.sv
// Operand-fetch stage: register file, A/B operand latches, the single-bit B shifter and the Ain/Bin selection.
// Build option OPERAND_BYPASS_EN (see operand_regfile) enables register-file write-through.
module operand_stage
  import operand_stage_pkg::*;
#(
  parameter int W    = operand_stage_pkg::W,
  parameter int NREG = operand_stage_pkg::NREG,
  parameter int AW   = operand_stage_pkg::AW
) (
  input  logic            clk,
  input  logic            reset,
  operand_stage_if.slave  bus
);

  logic [W-1:0] rd_p0;
  logic [W-1:0] a_p1;
  logic [W-1:0] b_p1;
  logic [W-1:0] bsh_p1;

  function automatic logic [W-1:0] shift_b(input logic [W-1:0] b, input logic [1:0] op);
    case (shift_e'(op))
      SH_LSL:  return {b[W-2:0], 1'b0};
      SH_LSR:  return {1'b0, b[W-1:1]};
      SH_ASR:  return {b[W-1], b[W-1:1]};
      default: return b;
    endcase
  endfunction

  // Stage p0: register-file read
  operand_regfile #(
    .W    (W),
    .NREG (NREG),
    .AW   (AW)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .write    (bus.write),
    .writenum (bus.writenum),
    .data_in  (bus.data_in),
    .readnum  (bus.readnum),
    .data_out (rd_p0)
  );

  assign bus.data_out = rd_p0;

  // Stage p1: operand latches, loaded from the read port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_p1 <= '0;
      b_p1 <= '0;
    end else begin
      if (bus.loada) a_p1 <= rd_p0;
      if (bus.loadb) b_p1 <= rd_p0;
    end
  end

  assign bsh_p1  = shift_b(b_p1, bus.shift);
  assign bus.Ain = bus.asel ? '0 : a_p1;
  assign bus.Bin = bus.bsel ? bus.sximm5 : bsh_p1;

endmodule
